mmr_write_arbiter: RTL and testbench

//  Sequences all writes into the 13-entry memory-mapped register bank through the MMR write demux.
//  Two requesters share the single demux write path:
//   - port A: CPU core store path
//   - port B: debug/DMA

---
 rtl/mmr_write_arbiter.sv | 107 ++++++++++
 tb/tb_mmr_write_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmr_write_arbiter.sv
// mmr_write_arbiter: round-robin arbiter that feeds two write requesters into the MMR write demux
// Optional feature: define MMR_WRITE_PROTECT_EN to add wp_mask (port B writes to masked indices are rejected)
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   a_req/a_addr/a_data   port A (CPU store path) request, target index, write data
//   a_ack/a_err           port A one-cycle completion pulse, rejection flag (valid with a_ack)
//   b_req/b_addr/b_data   port B (debug/DMA) request, target index, write data
//   b_ack/b_err           port B completion pulse, rejection flag
//   wp_mask               per-index write-protect mask (MMR_WRITE_PROTECT_EN only)
//   mmr_sel/mmr_data      demux select and data_in; IDLE_SEL and zero when not writing
//   mmr_we                bank load enable, one cycle per accepted write
//   busy                  high while a transaction is in WRITE or RESP
module mmr_write_arbiter #(
    parameter int DATA_W = 33,
    parameter int SEL_W = 4,
    parameter int NUM_MMR = 13,
    parameter logic [SEL_W-1:0] IDLE_SEL = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [SEL_W-1:0]  a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic [SEL_W-1:0]  b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    output logic              b_err,
`ifdef MMR_WRITE_PROTECT_EN
    input  logic [NUM_MMR-1:0] wp_mask,
`endif
    output logic [SEL_W-1:0]  mmr_sel,
    output logic [DATA_W-1:0] mmr_data,
    output logic              mmr_we,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
    state_t state;
    logic last_b;
    logic err_q;
    logic pick_b;
    logic [SEL_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic in_range;
    logic blocked;
    logic ok;
    // last_b doubles as the id of the port currently being served
    assign pick_b = b_req & (~a_req | ~last_b);
    assign addr_in = pick_b ? b_addr : a_addr;
    assign data_in = pick_b ? b_data : a_data;
    assign in_range = addr_in < SEL_W'(NUM_MMR);
`ifdef MMR_WRITE_PROTECT_EN
    assign blocked = pick_b & in_range & wp_mask[addr_in];
`else
    assign blocked = 1'b0;
`endif
    assign ok = in_range & ~blocked;
    // WRITE-cycle outputs are loaded on the grant edge so they are registered yet appear in WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_b <= 1'b1;
            err_q <= 1'b0;
            mmr_sel <= IDLE_SEL;
            mmr_data <= '0;
            mmr_we <= 1'b0;
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (a_req | b_req) begin
                    state <= WRITE;
                    busy <= 1'b1;
                    last_b <= pick_b;
                    err_q <= ~ok;
                    mmr_sel <= ok ? addr_in : IDLE_SEL;
                    mmr_data <= ok ? data_in : '0;
                    mmr_we <= ok;
                end
                WRITE: begin
                    state <= RESP;
                    mmr_sel <= IDLE_SEL;
                    mmr_data <= '0;
                    mmr_we <= 1'b0;
                    a_ack <= ~last_b;
                    a_err <= ~last_b & err_q;
                    b_ack <= last_b;
                    b_err <= last_b & err_q;
                end
                RESP: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmr_write_arbiter.sv
// tb_mmr_write_arbiter: directed self-checking bench for mmr_write_arbiter
module tb_mmr_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 1'b0, b_req = 1'b0;
    logic [3:0] a_addr = 4'd0, b_addr = 4'd0;
    logic [32:0] a_data = 33'd0, b_data = 33'd0;
    logic a_ack, a_err, b_ack, b_err, mmr_we, busy;
    logic [3:0] mmr_sel;
    logic [32:0] mmr_data;
`ifdef MMR_WRITE_PROTECT_EN
    logic [12:0] wp_mask = 13'h0;
`endif
    int vectors = 0;
    int miscompares = 0;

    mmr_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack), .b_err(b_err),
`ifdef MMR_WRITE_PROTECT_EN
        .wp_mask(wp_mask),
`endif
        .mmr_sel(mmr_sel), .mmr_data(mmr_data), .mmr_we(mmr_we), .busy(busy)
    );

    always #5 clk = ~clk;

    // requesters must hold addr/data stable until their ack
    logic a_held = 1'b0, b_held = 1'b0;
    logic [3:0] a_addr_p, b_addr_p;
    logic [32:0] a_data_p, b_data_p;
    always @(posedge clk) begin
        if (rst_n && a_held) assert (a_addr == a_addr_p && a_data == a_data_p) else $error("port A addr/data changed while pending");
        if (rst_n && b_held) assert (b_addr == b_addr_p && b_data == b_data_p) else $error("port B addr/data changed while pending");
        a_held <= a_req & ~a_ack;
        b_held <= b_req & ~b_ack;
        a_addr_p <= a_addr;
        a_data_p <= a_data;
        b_addr_p <= b_addr;
        b_data_p <= b_data;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we, a_ack, a_err, b_ack, b_err, busy} !== {4'hF, 33'd0, 6'b0}) begin
            miscompares++;
            $display("FAIL reset_vals: sel=%h data=%h we=%b a=%b%b b=%b%b busy=%b want F/0/0/00/00/0", mmr_sel, mmr_data, mmr_we, a_ack, a_err, b_ack, b_err, busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_a;
        a_req = 1'b1; a_addr = 4'd3; a_data = 33'h1_DEAD_BEEF;
        tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we, busy, a_ack} !== {4'd3, 33'h1_DEAD_BEEF, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL single_write: sel=%h data=%h we=%b busy=%b ack=%b want 3/1deadbeef/1/1/0", mmr_sel, mmr_data, mmr_we, busy, a_ack);
        end
        tick();
        vectors++;
        if ({a_ack, a_err, b_ack, mmr_we, mmr_sel} !== {4'b1000, 4'hF}) begin
            miscompares++;
            $display("FAIL single_resp: a_ack=%b a_err=%b b_ack=%b we=%b sel=%h want 1/0/0/0/F", a_ack, a_err, b_ack, mmr_we, mmr_sel);
        end
        a_req = 1'b0;
        tick();
        vectors++;
        if ({busy, a_ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle: busy=%b a_ack=%b want 0/0", busy, a_ack);
        end
    endtask

    task automatic test_tie;
        pulse_reset();
        a_req = 1'b1; a_addr = 4'd0; a_data = 33'h5;
        b_req = 1'b1; b_addr = 4'd12; b_data = 33'h7;
        tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we} !== {4'd0, 33'h5, 1'b1}) begin
            miscompares++;
            $display("FAIL tie_first: sel=%h data=%h we=%b want 0/5/1", mmr_sel, mmr_data, mmr_we);
        end
        tick();
        vectors++;
        if ({a_ack, b_ack} !== 2'b10) begin
            miscompares++;
            $display("FAIL tie_first_ack: a_ack=%b b_ack=%b want 1/0", a_ack, b_ack);
        end
        a_req = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_gap: busy=%b want 0", busy);
        end
        tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we} !== {4'd12, 33'h7, 1'b1}) begin
            miscompares++;
            $display("FAIL tie_second: sel=%h data=%h we=%b want c/7/1", mmr_sel, mmr_data, mmr_we);
        end
        tick();
        vectors++;
        if ({a_ack, b_ack, b_err} !== 3'b010) begin
            miscompares++;
            $display("FAIL tie_second_ack: a_ack=%b b_ack=%b b_err=%b want 0/1/0", a_ack, b_ack, b_err);
        end
        b_req = 1'b0;
        tick();
        // lone A write so A was granted last; the next tie must go to B
        a_req = 1'b1; a_addr = 4'd6; a_data = 33'h66;
        tick(); tick();
        a_req = 1'b0;
        tick();
        a_req = 1'b1; a_addr = 4'd1; a_data = 33'h11;
        b_req = 1'b1; b_addr = 4'd2; b_data = 33'h22;
        tick();
        vectors++;
        if ({mmr_sel, mmr_data} !== {4'd2, 33'h22}) begin
            miscompares++;
            $display("FAIL tie2_b_first: sel=%h data=%h want 2/22", mmr_sel, mmr_data);
        end
        tick();
        b_req = 1'b0;
        tick(); tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we} !== {4'd1, 33'h11, 1'b1}) begin
            miscompares++;
            $display("FAIL tie2_a_second: sel=%h data=%h we=%b want 1/11/1", mmr_sel, mmr_data, mmr_we);
        end
        tick();
        a_req = 1'b0;
        tick();
    endtask

    task automatic test_range;
        logic [3:0] bad [2] = '{4'd13, 4'd15};
        for (int i = 0; i < 2; i++) begin
            b_req = 1'b1; b_addr = bad[i]; b_data = 33'h1_2345_6789;
            tick();
            vectors++;
            if ({mmr_we, mmr_sel, mmr_data, busy} !== {1'b0, 4'hF, 33'd0, 1'b1}) begin
                miscompares++;
                $display("FAIL range_write[%0d]: we=%b sel=%h data=%h busy=%b want 0/F/0/1", bad[i], mmr_we, mmr_sel, mmr_data, busy);
            end
            tick();
            vectors++;
            if ({b_ack, b_err, a_ack, a_err} !== 4'b1100) begin
                miscompares++;
                $display("FAIL range_resp[%0d]: b_ack=%b b_err=%b a_ack=%b a_err=%b want 1/1/0/0", bad[i], b_ack, b_err, a_ack, a_err);
            end
            b_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid;
        a_req = 1'b1; a_addr = 4'd5; a_data = 33'h9;
        tick();
        vectors++;
        if (mmr_we !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: we=%b want 1", mmr_we);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we, a_ack, a_err, b_ack, b_err, busy} !== {4'hF, 33'd0, 6'b0}) begin
            miscompares++;
            $display("FAIL mid_async: sel=%h data=%h we=%b a_ack=%b busy=%b want F/0/0/0/0", mmr_sel, mmr_data, mmr_we, a_ack, busy);
        end
        tick();
        vectors++;
        if ({a_ack, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_no_ack: a_ack=%b busy=%b want 0/0", a_ack, busy);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({mmr_sel, mmr_data, mmr_we} !== {4'd5, 33'h9, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_after_write: sel=%h data=%h we=%b want 5/9/1", mmr_sel, mmr_data, mmr_we);
        end
        tick();
        vectors++;
        if ({a_ack, a_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_after_ack: a_ack=%b a_err=%b want 1/0", a_ack, a_err);
        end
        a_req = 1'b0;
        tick();
    endtask

`ifdef MMR_WRITE_PROTECT_EN
    task automatic test_protect;
        wp_mask = 13'h0010;
        b_req = 1'b1; b_addr = 4'd4; b_data = 33'h44;
        tick();
        vectors++;
        if ({mmr_we, mmr_sel} !== {1'b0, 4'hF}) begin
            miscompares++;
            $display("FAIL wp_b_write: we=%b sel=%h want 0/F", mmr_we, mmr_sel);
        end
        tick();
        vectors++;
        if ({b_ack, b_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL wp_b_resp: b_ack=%b b_err=%b want 1/1", b_ack, b_err);
        end
        b_req = 1'b0;
        tick();
        a_req = 1'b1; a_addr = 4'd4; a_data = 33'h45;
        tick();
        vectors++;
        if ({mmr_we, mmr_sel, mmr_data} !== {1'b1, 4'd4, 33'h45}) begin
            miscompares++;
            $display("FAIL wp_a_write: we=%b sel=%h data=%h want 1/4/45", mmr_we, mmr_sel, mmr_data);
        end
        tick();
        vectors++;
        if ({a_ack, a_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL wp_a_resp: a_ack=%b a_err=%b want 1/0", a_ack, a_err);
        end
        a_req = 1'b0;
        tick();
        wp_mask = 13'h0;
    endtask
`endif

    task automatic test_back_to_back;
        logic exp_b;
        pulse_reset();
        a_req = 1'b1; a_addr = 4'd1; a_data = 33'h0_AAAA_0001;
        b_req = 1'b1; b_addr = 4'd2; b_data = 33'h1_BBBB_0002;
        for (int k = 0; k < 36; k++) begin
            tick();
            exp_b = ((k / 3) % 2) == 1;
            if (k % 3 == 0) begin
                vectors++;
                if ({mmr_we, busy, mmr_sel, mmr_data} !== {2'b11, exp_b ? {4'd2, 33'h1_BBBB_0002} : {4'd1, 33'h0_AAAA_0001}}) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: we=%b busy=%b sel=%h data=%h want port %s", k, mmr_we, busy, mmr_sel, mmr_data, exp_b ? "B" : "A");
                end
            end else if (k % 3 == 1) begin
                vectors++;
                if ({a_ack, b_ack, mmr_we, busy} !== {~exp_b, exp_b, 2'b01}) begin
                    miscompares++;
                    $display("FAIL b2b_resp[%0d]: a_ack=%b b_ack=%b we=%b busy=%b want port %s", k, a_ack, b_ack, mmr_we, busy, exp_b ? "B" : "A");
                end
            end else begin
                vectors++;
                if ({a_ack, b_ack, mmr_we, busy} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL b2b_idle[%0d]: a_ack=%b b_ack=%b we=%b busy=%b want 0/0/0/0", k, a_ack, b_ack, mmr_we, busy);
                end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_range();
        test_reset_mid();
`ifdef MMR_WRITE_PROTECT_EN
        test_protect();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
